// File: rtl/axis_multi_ch_perf_monitor.sv
// Passive multi-channel AXI-Stream performance monitor: counts beats, packets,
// bytes and stall cycles per tap over a programmable window, then snapshots them.
module axis_multi_ch_perf_monitor #(
    parameter int NUM_CH     = 4,
    parameter int KEEP_WIDTH = 64,
    parameter int CNT_WIDTH  = 32,
    parameter int WIN_WIDTH  = 32
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [NUM_CH-1:0]              tap_tvalid,
    input  logic [NUM_CH-1:0]              tap_tready,
    input  logic [NUM_CH-1:0]              tap_tlast,
    input  logic [NUM_CH*KEEP_WIDTH-1:0]   tap_tkeep,
    input  logic                           cfg_start,
    input  logic                           cfg_abort,
    input  logic [WIN_WIDTH-1:0]           cfg_window,
    input  logic                           cfg_trig_en,
    input  logic [2:0]                     cfg_trig_ch,
    output logic                           busy,
    output logic                           done,
    output logic [WIN_WIDTH-1:0]           elapsed,
    output logic [NUM_CH*CNT_WIDTH-1:0]    snap_beats,
    output logic [NUM_CH*CNT_WIDTH-1:0]    snap_pkts,
    output logic [NUM_CH*CNT_WIDTH-1:0]    snap_bytes,
    output logic [NUM_CH*CNT_WIDTH-1:0]    snap_stalls,
    output logic [NUM_CH-1:0]              snap_sat
);

    localparam int PC_W = $clog2(KEEP_WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic logic [PC_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int j = 0; j < KEEP_WIDTH; j++) cnt = cnt + PC_W'(keep[j]);
        return cnt;
    endfunction

    // Returns {overflow, saturated sum}; the sum sticks at all-ones.
    function automatic logic [CNT_WIDTH:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_WIDTH] ? {1'b1, {CNT_WIDTH{1'b1}}} : sum;
    endfunction

    // Input register stage; popcount is folded in so bytes arrive with the beat.
    logic [NUM_CH-1:0] beat_q, last_q, stall_q;
    logic [PC_W-1:0]   nbytes_q [NUM_CH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            beat_q  <= '0;
            last_q  <= '0;
            stall_q <= '0;
            for (int i = 0; i < NUM_CH; i++) nbytes_q[i] <= '0;
        end else begin
            beat_q  <= tap_tvalid & tap_tready;
            last_q  <= tap_tvalid & tap_tready & tap_tlast;
            stall_q <= tap_tvalid & ~tap_tready;
            for (int i = 0; i < NUM_CH; i++) begin
                nbytes_q[i] <= (tap_tvalid[i] & tap_tready[i])
                             ? popcount(tap_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]) : '0;
            end
        end
    end

    state_e                 state_q, state_d;
    logic [WIN_WIDTH-1:0]   window_q, window_d;
    logic [2:0]             trig_ch_q, trig_ch_d;
    logic [WIN_WIDTH-1:0]   elapsed_q, elapsed_d;
    logic [CNT_WIDTH-1:0]   beats_q  [NUM_CH];
    logic [CNT_WIDTH-1:0]   beats_d  [NUM_CH];
    logic [CNT_WIDTH-1:0]   pkts_q   [NUM_CH];
    logic [CNT_WIDTH-1:0]   pkts_d   [NUM_CH];
    logic [CNT_WIDTH-1:0]   bytes_q  [NUM_CH];
    logic [CNT_WIDTH-1:0]   bytes_d  [NUM_CH];
    logic [CNT_WIDTH-1:0]   stalls_q [NUM_CH];
    logic [CNT_WIDTH-1:0]   stalls_d [NUM_CH];
    logic [NUM_CH-1:0]      sat_q, sat_d;

    logic [CNT_WIDTH:0]     sum_beats  [NUM_CH];
    logic [CNT_WIDTH:0]     sum_pkts   [NUM_CH];
    logic [CNT_WIDTH:0]     sum_bytes  [NUM_CH];
    logic [CNT_WIDTH:0]     sum_stalls [NUM_CH];
    logic                   trig_hit;
    logic                   count_en;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum_beats[i]  = sat_add(beats_q[i],  CNT_WIDTH'(beat_q[i]));
            sum_pkts[i]   = sat_add(pkts_q[i],   CNT_WIDTH'(last_q[i]));
            sum_bytes[i]  = sat_add(bytes_q[i],  CNT_WIDTH'(nbytes_q[i]));
            sum_stalls[i] = sat_add(stalls_q[i], CNT_WIDTH'(stall_q[i]));
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        window_d  = window_q;
        trig_ch_d = trig_ch_q;
        elapsed_d = elapsed_q;
        beats_d   = beats_q;
        pkts_d    = pkts_q;
        bytes_d   = bytes_q;
        stalls_d  = stalls_q;
        sat_d     = sat_q;
        trig_hit  = 1'b0;

        // Indices at or beyond NUM_CH match no channel and can never trigger.
        for (int i = 0; i < NUM_CH; i++) begin
            if (trig_ch_q == 3'(i) && beat_q[i]) trig_hit = 1'b1;
        end
        count_en = (state_q == ST_RUN) || (state_q == ST_ARMED && trig_hit);

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    elapsed_d = '0;
                    sat_d     = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        beats_d[i]  = '0;
                        pkts_d[i]   = '0;
                        bytes_d[i]  = '0;
                        stalls_d[i] = '0;
                    end
                    window_d  = cfg_window;
                    trig_ch_d = cfg_trig_ch;
                    state_d   = cfg_trig_en ? ST_ARMED : ST_RUN;
                end
            end
            ST_ARMED: if (trig_hit) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (count_en) begin
            elapsed_d = (elapsed_q == {WIN_WIDTH{1'b1}}) ? elapsed_q
                                                          : elapsed_q + WIN_WIDTH'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                beats_d[i]  = sum_beats[i][CNT_WIDTH-1:0];
                pkts_d[i]   = sum_pkts[i][CNT_WIDTH-1:0];
                bytes_d[i]  = sum_bytes[i][CNT_WIDTH-1:0];
                stalls_d[i] = sum_stalls[i][CNT_WIDTH-1:0];
                sat_d[i]    = sat_q[i] | sum_beats[i][CNT_WIDTH] | sum_pkts[i][CNT_WIDTH]
                            | sum_bytes[i][CNT_WIDTH] | sum_stalls[i][CNT_WIDTH];
            end
            // The cycle where elapsed reaches the window is the last one counted.
            if ((window_q != '0 && elapsed_d == window_q) ||
                (window_q == '0 && elapsed_d == {WIN_WIDTH{1'b1}})) begin
                state_d = ST_DONE;
            end
        end

        if ((state_q == ST_ARMED || state_q == ST_RUN) && cfg_abort) state_d = ST_DONE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            window_q  <= '0;
            trig_ch_q <= '0;
            elapsed_q <= '0;
            sat_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                beats_q[i]  <= '0;
                pkts_q[i]   <= '0;
                bytes_q[i]  <= '0;
                stalls_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            window_q  <= window_d;
            trig_ch_q <= trig_ch_d;
            elapsed_q <= elapsed_d;
            sat_q     <= sat_d;
            beats_q   <= beats_d;
            pkts_q    <= pkts_d;
            bytes_q   <= bytes_d;
            stalls_q  <= stalls_d;
        end
    end

    // Snapshots load with the final counts as the FSM enters DONE, so they are
    // valid during the done pulse and hold until the next one.
    logic [WIN_WIDTH-1:0] elapsed_snap_q;
    logic [CNT_WIDTH-1:0] snap_beats_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] snap_pkts_q   [NUM_CH];
    logic [CNT_WIDTH-1:0] snap_bytes_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] snap_stalls_q [NUM_CH];
    logic [NUM_CH-1:0]    snap_sat_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            elapsed_snap_q <= '0;
            snap_sat_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                snap_beats_q[i]  <= '0;
                snap_pkts_q[i]   <= '0;
                snap_bytes_q[i]  <= '0;
                snap_stalls_q[i] <= '0;
            end
        end else if (state_d == ST_DONE) begin
            elapsed_snap_q <= elapsed_d;
            snap_sat_q     <= sat_d;
            snap_beats_q   <= beats_d;
            snap_pkts_q    <= pkts_d;
            snap_bytes_q   <= bytes_d;
            snap_stalls_q  <= stalls_d;
        end
    end

    assign busy    = (state_q == ST_ARMED) || (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign elapsed = elapsed_snap_q;
    assign snap_sat = snap_sat_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign snap_beats[g*CNT_WIDTH +: CNT_WIDTH]  = snap_beats_q[g];
        assign snap_pkts[g*CNT_WIDTH +: CNT_WIDTH]   = snap_pkts_q[g];
        assign snap_bytes[g*CNT_WIDTH +: CNT_WIDTH]  = snap_bytes_q[g];
        assign snap_stalls[g*CNT_WIDTH +: CNT_WIDTH] = snap_stalls_q[g];
    end

endmodule

// File: tb/tb_axis_multi_ch_perf_monitor.sv
// Scoreboard bench for axis_multi_ch_perf_monitor: a 32-bit-counter instance is
// checked through the expectation queue; an 8-bit-counter twin covers saturation.
module tb_axis_multi_ch_perf_monitor;

    localparam int NCH = 2;
    localparam int KW  = 64;
    localparam int CW  = 32;
    localparam int WW  = 32;
    localparam int CWB = 8;

    typedef enum int {M_IDLE, M_STREAM0, M_BP1, M_TRIG} mode_e;

    typedef struct {
        string                   name;
        logic [WW-1:0]           elapsed;
        logic [NCH-1:0][CW-1:0]  beats;
        logic [NCH-1:0][CW-1:0]  pkts;
        logic [NCH-1:0][CW-1:0]  bytes;
        logic [NCH-1:0][CW-1:0]  stalls;
        logic [NCH-1:0]          sat;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NCH-1:0]     tvalid, tready, tlast;
    logic [NCH*KW-1:0]  tkeep;
    logic               cfg_start, cfg_abort, cfg_trig_en;
    logic [WW-1:0]      cfg_window;
    logic [2:0]         cfg_trig_ch;

    logic               a_busy, a_done;
    logic [WW-1:0]      a_elapsed;
    logic [NCH*CW-1:0]  a_beats, a_pkts, a_bytes, a_stalls;
    logic [NCH-1:0]     a_sat;

    logic               b_busy, b_done;
    logic [WW-1:0]      b_elapsed;
    logic [NCH*CWB-1:0] b_beats, b_pkts, b_bytes, b_stalls;
    logic [NCH-1:0]     b_sat;

    int    errors   = 0;
    int    checks   = 0;
    int    done_cnt = 0;
    int    k        = 0;
    mode_e mode     = M_IDLE;
    logic [KW-1:0] bp_keep = '1;
    exp_t  sb_q [$];

    always #5 clk = ~clk;

    axis_multi_ch_perf_monitor #(
        .NUM_CH(NCH), .KEEP_WIDTH(KW), .CNT_WIDTH(CW), .WIN_WIDTH(WW)
    ) dut_a (
        .CLK(clk), .RST_N(rst_n),
        .tap_tvalid(tvalid), .tap_tready(tready), .tap_tlast(tlast), .tap_tkeep(tkeep),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_window(cfg_window),
        .cfg_trig_en(cfg_trig_en), .cfg_trig_ch(cfg_trig_ch),
        .busy(a_busy), .done(a_done), .elapsed(a_elapsed),
        .snap_beats(a_beats), .snap_pkts(a_pkts), .snap_bytes(a_bytes),
        .snap_stalls(a_stalls), .snap_sat(a_sat)
    );

    axis_multi_ch_perf_monitor #(
        .NUM_CH(NCH), .KEEP_WIDTH(KW), .CNT_WIDTH(CWB), .WIN_WIDTH(WW)
    ) dut_b (
        .CLK(clk), .RST_N(rst_n),
        .tap_tvalid(tvalid), .tap_tready(tready), .tap_tlast(tlast), .tap_tkeep(tkeep),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_window(cfg_window),
        .cfg_trig_en(cfg_trig_en), .cfg_trig_ch(cfg_trig_ch),
        .busy(b_busy), .done(b_done), .elapsed(b_elapsed),
        .snap_beats(b_beats), .snap_pkts(b_pkts), .snap_bytes(b_bytes),
        .snap_stalls(b_stalls), .snap_sat(b_sat)
    );

    function automatic exp_t zero_exp(input string n);
        exp_t e;
        e.name    = n;
        e.elapsed = '0;
        e.beats   = '0;
        e.pkts    = '0;
        e.bytes   = '0;
        e.stalls  = '0;
        e.sat     = '0;
        return e;
    endfunction

    // Tap pattern for the next rising edge; k counts edges since set_mode.
    task automatic drive_taps();
        tvalid = '0;
        tready = '0;
        tlast  = '0;
        tkeep  = '0;
        case (mode)
            M_STREAM0: begin
                tvalid[0] = 1'b1;
                tready[0] = 1'b1;
                tlast[0]  = (k % 4 == 3);
                tkeep[KW-1:0] = '1;
            end
            M_BP1: begin
                tvalid[1] = 1'b1;
                tready[1] = (k % 2 == 0);
                tkeep[2*KW-1:KW] = bp_keep;
            end
            M_TRIG: begin
                tvalid[0] = 1'b1;
                tready[0] = 1'b1;
                tkeep[KW-1:0] = '1;
                if (k >= 37) begin
                    tvalid[1] = 1'b1;
                    tready[1] = 1'b1;
                    tkeep[2*KW-1:KW] = '1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic set_mode(input mode_e m);
        mode = m;
        k    = 0;
        drive_taps();
    endtask

    // One clock: sample at the falling edge, score any done, drive next taps.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (a_done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty queue, want none");
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (a_elapsed !== e.elapsed) begin
                    errors++;
                    $display("FAIL %s elapsed: got %0d want %0d", e.name, a_elapsed, e.elapsed);
                end
                checks++;
                if (a_sat !== e.sat) begin
                    errors++;
                    $display("FAIL %s snap_sat: got %b want %b", e.name, a_sat, e.sat);
                end
                for (int ch = 0; ch < NCH; ch++) begin
                    checks++;
                    if (a_beats[ch*CW +: CW] !== e.beats[ch]) begin
                        errors++;
                        $display("FAIL %s beats[%0d]: got %0d want %0d", e.name, ch, a_beats[ch*CW +: CW], e.beats[ch]);
                    end
                    checks++;
                    if (a_pkts[ch*CW +: CW] !== e.pkts[ch]) begin
                        errors++;
                        $display("FAIL %s pkts[%0d]: got %0d want %0d", e.name, ch, a_pkts[ch*CW +: CW], e.pkts[ch]);
                    end
                    checks++;
                    if (a_bytes[ch*CW +: CW] !== e.bytes[ch]) begin
                        errors++;
                        $display("FAIL %s bytes[%0d]: got %0d want %0d", e.name, ch, a_bytes[ch*CW +: CW], e.bytes[ch]);
                    end
                    checks++;
                    if (a_stalls[ch*CW +: CW] !== e.stalls[ch]) begin
                        errors++;
                        $display("FAIL %s stalls[%0d]: got %0d want %0d", e.name, ch, a_stalls[ch*CW +: CW], e.stalls[ch]);
                    end
                end
            end
        end
        k++;
        drive_taps();
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        d0 = done_cnt;
        for (int c = 0; c < budget && done_cnt == d0; c++) step();
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", tag, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_abort = 1'b0; cfg_trig_en = 1'b0;
        cfg_window = '0; cfg_trig_ch = '0;
        set_mode(M_IDLE);
        repeat (3) @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b done=%b want 0 0", a_busy, a_done);
        end
        checks++;
        if (a_elapsed !== '0 || a_beats !== '0 || a_bytes !== '0 || a_sat !== '0) begin
            errors++;
            $display("FAIL reset_snap: got elapsed=%0d beats=%h bytes=%h sat=%b want zeros", a_elapsed, a_beats, a_bytes, a_sat);
        end
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b/%b dones=%0d want 0/0 0", a_busy, b_busy, done_cnt);
        end
    endtask

    task automatic test_basic_window(input string tag);
        exp_t e;
        int   d0;
        e = zero_exp(tag);
        e.elapsed  = 100;
        e.beats[0] = 100;
        e.pkts[0]  = 25;
        e.bytes[0] = 6400;
        sb_q.push_back(e);
        cfg_window  = 100;
        cfg_trig_en = 1'b0;
        set_mode(M_STREAM0);
        d0 = done_cnt;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        wait_done(150, tag);
        repeat (5) step();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt - d0);
        end
        set_mode(M_IDLE);
        step();
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [KW-1:0] keeps [2];
        int   want_bytes [2];
        keeps[0] = '1;
        keeps[1] = 64'h0000_0000_0000_FFFF;
        want_bytes[0] = 320;
        want_bytes[1] = 80;
        for (int r = 0; r < 2; r++) begin
            e = zero_exp($sformatf("backpressure_%0d", r));
            e.elapsed   = 10;
            e.beats[1]  = 5;
            e.stalls[1] = 5;
            e.bytes[1]  = want_bytes[r];
            sb_q.push_back(e);
            bp_keep    = keeps[r];
            cfg_window = 10;
            set_mode(M_BP1);
            cfg_start = 1'b1;
            step();
            cfg_start = 1'b0;
            wait_done(30, e.name);
            set_mode(M_IDLE);
            repeat (3) step();
        end
    endtask

    task automatic test_trigger();
        exp_t e;
        int   d0, busy_low, lat;
        e = zero_exp("trigger");
        e.elapsed  = 50;
        e.beats[0] = 50;
        e.beats[1] = 50;
        e.bytes[0] = 3200;
        e.bytes[1] = 3200;
        sb_q.push_back(e);
        cfg_window  = 50;
        cfg_trig_en = 1'b1;
        cfg_trig_ch = 3'd1;
        set_mode(M_TRIG);
        d0 = done_cnt;
        busy_low = 0;
        lat = 0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        if (a_busy !== 1'b1) busy_low++;
        for (int c = 1; c <= 200 && done_cnt == d0; c++) begin
            step();
            if (done_cnt == d0 && a_busy !== 1'b1) busy_low++;
            lat = c;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL trigger timeout: no done within 200 cycles");
        end
        checks++;
        if (busy_low != 0) begin
            errors++;
            $display("FAIL trigger busy: got %0d low cycles want 0", busy_low);
        end
        checks++;
        if (lat != 87) begin
            errors++;
            $display("FAIL trigger done_latency: got %0d want 87", lat);
        end
        cfg_trig_en = 1'b0;
        cfg_trig_ch = 3'd0;
        set_mode(M_IDLE);
        repeat (3) step();
    endtask

    task automatic test_abort();
        exp_t e;
        int   d0;
        e = zero_exp("abort");
        e.elapsed  = 20;
        e.beats[0] = 20;
        e.pkts[0]  = 5;
        e.bytes[0] = 1280;
        sb_q.push_back(e);
        cfg_window = 0;
        set_mode(M_STREAM0);
        d0 = done_cnt;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        repeat (9) step();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        repeat (9) step();
        checks++;
        if (a_busy !== 1'b1 || done_cnt != d0) begin
            errors++;
            $display("FAIL abort pre_state: got busy=%b dones=%0d want 1 0", a_busy, done_cnt - d0);
        end
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        checks++;
        if (a_done !== 1'b1) begin
            errors++;
            $display("FAIL abort done_latency: got done=%b want 1", a_done);
        end
        step();
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        repeat (3) step();
        checks++;
        if (done_cnt - d0 != 1 || a_busy !== 1'b0 || a_elapsed !== 32'd20) begin
            errors++;
            $display("FAIL abort idle_ignore: got dones=%0d busy=%b elapsed=%0d want 1 0 20", done_cnt - d0, a_busy, a_elapsed);
        end
        set_mode(M_IDLE);
        step();
    endtask

    task automatic test_trig_out_of_range();
        exp_t e;
        int   d0;
        e = zero_exp("trig_oob");
        sb_q.push_back(e);
        cfg_window  = 10;
        cfg_trig_en = 1'b1;
        cfg_trig_ch = 3'd5;
        set_mode(M_STREAM0);
        d0 = done_cnt;
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL trig_oob start_wins: got busy=%b want 1", a_busy);
        end
        repeat (30) step();
        checks++;
        if (a_busy !== 1'b1 || done_cnt != d0) begin
            errors++;
            $display("FAIL trig_oob armed_hold: got busy=%b dones=%0d want 1 0", a_busy, done_cnt - d0);
        end
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        step();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL trig_oob abort_exit: got %0d dones want 1", done_cnt - d0);
        end
        cfg_trig_en = 1'b0;
        cfg_trig_ch = 3'd0;
        set_mode(M_IDLE);
        repeat (2) step();
    endtask

    task automatic test_saturation();
        exp_t e;
        e = zero_exp("saturation_wide");
        e.elapsed  = 300;
        e.beats[0] = 300;
        e.pkts[0]  = 75;
        e.bytes[0] = 19200;
        sb_q.push_back(e);
        cfg_window = 300;
        set_mode(M_STREAM0);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        wait_done(350, "saturation");
        checks++;
        if (b_done !== 1'b1 || b_elapsed !== 32'd300) begin
            errors++;
            $display("FAIL sat_narrow done: got done=%b elapsed=%0d want 1 300", b_done, b_elapsed);
        end
        checks++;
        if (b_beats[CWB-1:0] !== 8'd255 || b_bytes[CWB-1:0] !== 8'd255) begin
            errors++;
            $display("FAIL sat_narrow ch0: got beats=%0d bytes=%0d want 255 255", b_beats[CWB-1:0], b_bytes[CWB-1:0]);
        end
        checks++;
        if (b_pkts[CWB-1:0] !== 8'd75 || b_beats[2*CWB-1:CWB] !== 8'd0) begin
            errors++;
            $display("FAIL sat_narrow other: got pkts0=%0d beats1=%0d want 75 0", b_pkts[CWB-1:0], b_beats[2*CWB-1:CWB]);
        end
        checks++;
        if (b_sat !== 2'b01) begin
            errors++;
            $display("FAIL sat_narrow flags: got %b want 01", b_sat);
        end
        set_mode(M_IDLE);
        repeat (3) step();
    endtask

    task automatic test_reset_mid_window();
        int d0;
        cfg_window = 100;
        set_mode(M_STREAM0);
        d0 = done_cnt;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        repeat (39) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_elapsed !== '0) begin
            errors++;
            $display("FAIL rst_mid ctrl: got busy=%b done=%b elapsed=%0d want 0 0 0", a_busy, a_done, a_elapsed);
        end
        checks++;
        if (a_beats !== '0 || a_pkts !== '0 || a_bytes !== '0 || a_sat !== '0) begin
            errors++;
            $display("FAIL rst_mid snap_a: got beats=%h pkts=%h bytes=%h sat=%b want zeros", a_beats, a_pkts, a_bytes, a_sat);
        end
        checks++;
        if (b_beats !== '0 || b_sat !== '0 || b_elapsed !== '0) begin
            errors++;
            $display("FAIL rst_mid snap_b: got beats=%h sat=%b elapsed=%0d want zeros", b_beats, b_sat, b_elapsed);
        end
        @(posedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid busy_edge: got %b/%b want 0/0", a_busy, b_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_mode(M_IDLE);
        repeat (3) step();
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL rst_mid stray_done: got %0d dones want 0", done_cnt - d0);
        end
        test_basic_window("rerun_after_reset");
    endtask

    initial begin
        test_reset();
        test_basic_window("basic_window");
        test_backpressure();
        test_trigger();
        test_abort();
        test_trig_out_of_range();
        test_saturation();
        test_reset_mid_window();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
